dma_isr_req_split: RTL
======================

// Module: dma_isr_req_split
// PURPOSE
// - Downstream consumer of the DMA ISR request register-slice chain; feeds the host DMA engine.
// - Splits each ISR DMA request into chunks that are at most MAX_XFER bytes and never cross a BOUNDARY-aligned host address.
// - Host and card addresses advance together; the original request's last/isr attributes are carried to the chunks.
// PARAMETERS
// - ADDR_BITS  64    host/card address width
// - LEN_BITS   28    byte length width
// - MAX_XFER   4096  max chunk bytes; power of two, <= BOUNDARY
// - BOUNDARY   4096  host address crossing limit; power of two
// PORTS
// - aclk               in   1          clock
// - areset             in   1          asynchronous, active-high reset
// - s_req_valid        in   1          upstream request valid
// - s_req_ready        out  1          upstream request accepted when valid&ready
// - s_req_paddr_host   in   ADDR_BITS  host physical address
// - s_req_paddr_card   in   ADDR_BITS  card physical address
// - s_req_len          in   LEN_BITS   total bytes
// - s_req_last         in   1          request ends a transfer; completion required
// - s_req_isr          in   1          ISR (host-sync) request flag
// - m_req_valid        out  1          chunk valid
// - m_req_ready        in   1          chunk accepted when valid&ready
// - m_req_paddr_host   out  ADDR_BITS  chunk host address
// - m_req_paddr_card   out  ADDR_BITS  chunk card address
// - m_req_len          out  LEN_BITS   chunk bytes
// - m_req_last         out  1          last chunk of a last request
// - m_req_isr          out  1          copy of s_req_isr
// BEHAVIOUR
// - Reset: state IDLE; all m_req_* outputs 0, s_req_ready 0, all internal address/length registers 0.
// - FSM IDLE: s_req_ready = !m_req_valid | m_req_ready. On accept, latch addresses/len/last/isr and go to SPLIT.
// - FSM SPLIT:
//   - Each cycle with the output slot free (!m_req_valid | m_req_ready), present one chunk:
//     chunk = min(rem, MAX_XFER, BOUNDARY - (host_addr & (BOUNDARY-1))).
//   - Registered output. Both addresses += chunk; rem -= chunk.
//   - If the new rem == 0: m_req_last = latched last, else 0. Return to IDLE.
// - s_req_ready is 0 throughout SPLIT; no new request is accepted until the final chunk is loaded into the output register.
// - Latency: first chunk m_req_valid one cycle after the accepting edge.
// - Throughput: one chunk per cycle while m_req_ready = 1.
// - Output hold: m_req_* stable while m_req_valid & !m_req_ready.
// - Zero length (s_req_len == 0): forwarded as a single chunk (len 0, original addresses, last/isr copied).
// - Arithmetic:
//   - Chunk math in LEN_BITS; address adds wrap modulo 2^ADDR_BITS with no error.
//   - MAX_XFER/BOUNDARY are elaborated as constants.
// - Reset mid-SPLIT: the remaining chunks are discarded; the partial request is not resumed.
// CONFIGURATION
// - DMA_ISR_SPLIT_STATS_EN defined: adds outputs
//   - stat_reqs  out 32: accepted requests
//   - stat_chunks out 32: m_req handshakes
//   - Both clear on areset and wrap at 2^32.
// - Undefined: those ports and counters do not exist; datapath behaviour is identical.
// TESTING
// - host 0x1000, len 0x3000 -> 3 chunks of 0x1000 at host 0x1000/0x2000/0x3000; card advances in step; last only on chunk 3 when s_req_last=1.
// - host 0x0F00, len 0x200 -> chunks (0x0F00,0x100), (0x1000,0x100).
// - host 0x0, len 0x1800, m_req_ready toggling 1/0 -> 2 chunks, outputs held during stalls, s_req_ready low until the 2nd chunk is loaded.
// - len 0, last=1, isr=1 -> one chunk len 0 with last=1 and isr=1; next request accepted the following cycle.
// - areset asserted after chunk 1 of a 4-chunk request -> all outputs 0 immediately; a new request afterwards splits correctly.
// - Stats build: 3 requests totalling 7 chunks -> stat_reqs=3, stat_chunks=7.

Source files
------------

// File: rtl/dma_isr_req_split.sv
// -----------------------------------------------------------------------------
// dma_isr_req_split
//
// Purpose:
//   Takes ISR DMA requests from the upstream register-slice chain and feeds
//   the host DMA engine with chunks. Each chunk is at most MAX_XFER bytes and
//   never crosses a BOUNDARY-aligned host address. Host and card addresses
//   advance together. The request's isr flag is copied to every chunk. The
//   request's last flag is copied only to the final chunk.
//
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   s_req_*             upstream request (valid/ready), one request at a time
//   m_req_*             downstream chunk (valid/ready), registered outputs
//   stat_reqs           accepted requests   (only with DMA_ISR_SPLIT_STATS_EN)
//   stat_chunks         m_req handshakes    (only with DMA_ISR_SPLIT_STATS_EN)
//
// Handshake rule (both interfaces):
//   A transfer happens on a rising aclk edge where valid & ready are both 1.
//   A valid that is raised stays raised, with its payload stable, until the
//   transfer happens. ready may depend combinationally on the consumer's state.
//
// Configuration macro:
//   DMA_ISR_SPLIT_STATS_EN - adds the stat_reqs / stat_chunks counter outputs.
//   The datapath behaves the same whether or not the macro is defined.
// -----------------------------------------------------------------------------
module dma_isr_req_split #(
   parameter int ADDR_BITS = 64,
   parameter int LEN_BITS  = 28,
   parameter int MAX_XFER  = 4096,
   parameter int BOUNDARY  = 4096
) (
   input  logic                 aclk,
   input  logic                 areset,

   input  logic                 s_req_valid,
   output logic                 s_req_ready,
   input  logic [ADDR_BITS-1:0] s_req_paddr_host,
   input  logic [ADDR_BITS-1:0] s_req_paddr_card,
   input  logic [LEN_BITS-1:0]  s_req_len,
   input  logic                 s_req_last,
   input  logic                 s_req_isr,

   output logic                 m_req_valid,
   input  logic                 m_req_ready,
   output logic [ADDR_BITS-1:0] m_req_paddr_host,
   output logic [ADDR_BITS-1:0] m_req_paddr_card,
   output logic [LEN_BITS-1:0]  m_req_len,
   output logic                 m_req_last,
   output logic                 m_req_isr
`ifdef DMA_ISR_SPLIT_STATS_EN
   ,
   output logic [31:0]          stat_reqs,
   output logic [31:0]          stat_chunks
`endif
);

   // Low host address bits that give the offset inside a BOUNDARY window.
   localparam int BND_BITS = $clog2(BOUNDARY);
   localparam logic [LEN_BITS-1:0] MAX_XFER_L = LEN_BITS'(MAX_XFER);
   localparam logic [LEN_BITS-1:0] BOUNDARY_L = LEN_BITS'(BOUNDARY);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SPLIT = 1'b1
   } state_e;

   state_e               state_q;
   logic [ADDR_BITS-1:0] host_q;
   logic [ADDR_BITS-1:0] card_q;
   logic [LEN_BITS-1:0]  rem_q;
   logic                 last_q;
   logic                 isr_q;

   logic                 slot_free;
   logic                 s_accept;
   logic                 m_fire;
   logic [LEN_BITS-1:0]  room;
   logic [LEN_BITS-1:0]  chunk;
   logic [LEN_BITS-1:0]  rem_d;
   logic [ADDR_BITS-1:0] host_d;
   logic [ADDR_BITS-1:0] card_d;

   // The output register can take a new chunk when it is empty or when its
   // current chunk is consumed on this edge.
   assign slot_free = !m_req_valid || m_req_ready;
   assign m_fire    = m_req_valid && m_req_ready;

   // A new request is accepted only in IDLE. IDLE is reached only after the
   // final chunk of the previous request has been loaded. The areset term keeps
   // ready at 0 while reset is held, as the other outputs are.
   assign s_req_ready = (state_q == ST_IDLE) && slot_free && !areset;
   assign s_accept    = s_req_valid && s_req_ready;

   // Chunk size: min(rem, MAX_XFER, bytes left before the next host boundary).
   // room is always in 1..BOUNDARY. A zero-length request therefore yields one
   // zero-length chunk, and that chunk ends the request.
   always_comb begin
      room   = BOUNDARY_L - LEN_BITS'(host_q[BND_BITS-1:0]);
      chunk  = rem_q;
      if (chunk > MAX_XFER_L) begin
         chunk = MAX_XFER_L;
      end
      if (chunk > room) begin
         chunk = room;
      end
      rem_d  = rem_q - chunk;
      // Address adds wrap modulo 2^ADDR_BITS.
      host_d = host_q + ADDR_BITS'(chunk);
      card_d = card_q + ADDR_BITS'(chunk);
   end

   // Control FSM and registered datapath.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q          <= ST_IDLE;
         host_q           <= '0;
         card_q           <= '0;
         rem_q            <= '0;
         last_q           <= 1'b0;
         isr_q            <= 1'b0;
         m_req_valid      <= 1'b0;
         m_req_paddr_host <= '0;
         m_req_paddr_card <= '0;
         m_req_len        <= '0;
         m_req_last       <= 1'b0;
         m_req_isr        <= 1'b0;
      end else begin
         // A consumed chunk empties the slot unless a new chunk is loaded below.
         if (m_fire) begin
            m_req_valid <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (s_accept) begin
                  host_q  <= s_req_paddr_host;
                  card_q  <= s_req_paddr_card;
                  rem_q   <= s_req_len;
                  last_q  <= s_req_last;
                  isr_q   <= s_req_isr;
                  state_q <= ST_SPLIT;
               end
            end

            ST_SPLIT: begin
               if (slot_free) begin
                  m_req_valid      <= 1'b1;
                  m_req_paddr_host <= host_q;
                  m_req_paddr_card <= card_q;
                  m_req_len        <= chunk;
                  m_req_isr        <= isr_q;
                  m_req_last       <= (rem_d == '0) ? last_q : 1'b0;
                  host_q           <= host_d;
                  card_q           <= card_d;
                  rem_q            <= rem_d;
                  if (rem_d == '0) begin
                     state_q <= ST_IDLE;
                  end
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef DMA_ISR_SPLIT_STATS_EN
   // Free-running event counters that wrap at 2^32.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         stat_reqs   <= 32'd0;
         stat_chunks <= 32'd0;
      end else begin
         if (s_accept) begin
            stat_reqs <= stat_reqs + 32'd1;
         end
         if (m_fire) begin
            stat_chunks <= stat_chunks + 32'd1;
         end
      end
   end
`endif

endmodule
